// File: rtl/lynxTypes.sv
// Shared type package: stream widths, routing-entry struct and width helpers
// used by the data path blocks. dest_data_mux imports it with lynxTypes::*.
package lynxTypes;

    // Default stream data width and the widths of the routing-entry fields
    localparam int AXI_DATA_BITS = 512;
    localparam int BLEN_BITS     = 28;
    localparam int PID_BITS      = 6;
    localparam int N_DESTS_BITS  = 4;

    // Routing entry: owning pid, transfer length in beats minus one, source select
    typedef struct packed {
        logic [PID_BITS-1:0]     pid;
        logic [BLEN_BITS-1:0]    len;
        logic [N_DESTS_BITS-1:0] dest;
    } mux_user_t;

    // Ceiling log2 that never returns zero, so a one-entry select still has a bit
    function automatic int clog2s(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/dest_data_mux.sv
// dest_data_mux: merges N_DESTS AXI-Stream sources onto one output stream.
// A routing entry {pid, len, dest} selects which source feeds the output for
// the next len+1 beats; tlast is generated locally from the beat count and the
// source tlast is ignored. The data path is purely combinational (no buffering)
// and a new entry is accepted on the last beat so transfers run back-to-back.
// Optional build macro DEST_DATA_MUX_STATS_EN adds the cnt_xfers output, a
// 32-bit wrapping count of completed transfers.
module dest_data_mux
    import lynxTypes::*;
#(
    parameter int DATA_BITS = AXI_DATA_BITS,
    parameter int N_DESTS   = 1
) (
    input  logic                                  aclk,
    input  logic                                  areset,

    input  mux_user_t                             mux_data,
    input  logic                                  mux_valid,
    output logic                                  mux_ready,

    input  logic [N_DESTS-1:0]                    s_axis_tvalid,
    output logic [N_DESTS-1:0]                    s_axis_tready,
    input  logic [N_DESTS-1:0][DATA_BITS-1:0]     s_axis_tdata,
    input  logic [N_DESTS-1:0][DATA_BITS/8-1:0]   s_axis_tkeep,
    input  logic [N_DESTS-1:0]                    s_axis_tlast,

    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic [DATA_BITS-1:0]                  m_axis_tdata,
    output logic [DATA_BITS/8-1:0]                m_axis_tkeep,
    output logic                                  m_axis_tlast
`ifdef DEST_DATA_MUX_STATS_EN
    ,
    output logic [31:0]                           cnt_xfers
`endif
);

    localparam int SEL_BITS = clog2s(N_DESTS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t               state_r;
    logic [SEL_BITS-1:0]  dest_r;
    logic [BLEN_BITS-1:0] len_r;
    logic [BLEN_BITS-1:0] cnt_r;

    logic                 sel_valid_s;
    logic                 beat_hs_s;
    logic                 last_hs_s;
    logic                 mux_hs_s;
    logic [SEL_BITS-1:0]  new_dest_s;
    logic                 unused_s;

    // pid, the upper dest bits and the source tlast carry no meaning here
    assign unused_s = ^{mux_data.pid, mux_data.dest, s_axis_tlast};

    assign beat_hs_s = (state_r == XFER) && m_axis_tvalid && m_axis_tready;
    assign last_hs_s = beat_hs_s && m_axis_tlast;
    assign mux_hs_s  = mux_valid && mux_ready;

    // Source select taken from a new entry; a single source is always source 0
    always_comb begin
        new_dest_s = '0;
        if (N_DESTS > 1) begin
            new_dest_s = mux_data.dest[SEL_BITS-1:0];
        end else begin
            new_dest_s = '0;
        end
    end

    // Output steering and handshakes; everything is forced quiet during reset
    always_comb begin
        sel_valid_s   = 1'b0;
        mux_ready     = 1'b0;
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        case (state_r)
            IDLE: begin
                mux_ready = ~areset;
            end
            XFER: begin
                // An out-of-range select simply stalls rather than reading garbage
                if (!areset && (int'(dest_r) < N_DESTS)) begin
                    sel_valid_s           = s_axis_tvalid[dest_r];
                    m_axis_tdata          = s_axis_tdata[dest_r];
                    m_axis_tkeep          = s_axis_tkeep[dest_r];
                    m_axis_tlast          = (cnt_r == len_r);
                    s_axis_tready[dest_r] = m_axis_tready;
                    m_axis_tvalid         = sel_valid_s;
                    mux_ready             = sel_valid_s && m_axis_tready && m_axis_tlast;
                end else begin
                    sel_valid_s = 1'b0;
                end
            end
            default: begin
                mux_ready = 1'b0;
            end
        endcase
    end

    // Transfer FSM, latched routing entry and beat counter
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r <= IDLE;
            dest_r  <= '0;
            len_r   <= '0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mux_hs_s) begin
                        dest_r  <= new_dest_s;
                        len_r   <= mux_data.len;
                        cnt_r   <= '0;
                        state_r <= XFER;
                    end
                end
                XFER: begin
                    if (last_hs_s) begin
                        cnt_r <= '0;
                        if (mux_hs_s) begin
                            dest_r <= new_dest_s;
                            len_r  <= mux_data.len;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (beat_hs_s) begin
                        cnt_r <= cnt_r + BLEN_BITS'(1'b1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef DEST_DATA_MUX_STATS_EN
    // Completed-transfer counter, wraps naturally at 2^32
    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_xfers <= 32'd0;
        end else if (last_hs_s) begin
            cnt_xfers <= cnt_xfers + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dest_data_mux.sv
// Bench for dest_data_mux (4 sources, 32-bit data). Sources replay per-source
// word arrays; each accepted routing entry pushes the words it must carry onto
// an expected-beat queue, and a negedge monitor compares the DUT against it.
module tb_dest_data_mux;
    import lynxTypes::*;

    localparam int DW    = 32;
    localparam int KW    = DW / 8;
    localparam int ND    = 4;
    localparam int DEPTH = 256;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        int            dest;
    } beat_t;

    typedef struct {
        int dest;
        int len;
    } ent_t;

    logic                      aclk = 1'b0;
    logic                      areset;
    mux_user_t                 mux_data;
    logic                      mux_valid;
    logic                      mux_ready;
    logic [ND-1:0]             s_axis_tvalid;
    logic [ND-1:0]             s_axis_tready;
    logic [ND-1:0][DW-1:0]     s_axis_tdata;
    logic [ND-1:0][KW-1:0]     s_axis_tkeep;
    logic [ND-1:0]             s_axis_tlast;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready;
    logic [DW-1:0]             m_axis_tdata;
    logic [KW-1:0]             m_axis_tkeep;
    logic                      m_axis_tlast;
`ifdef DEST_DATA_MUX_STATS_EN
    logic [31:0]               cnt_xfers;
    int                        xfers_model = 0;
    logic                      seen_rst = 1'b0;
`endif

    beat_t          exp_q[$];
    ent_t           mux_q[$];
    logic [DW-1:0]  src_data [ND][DEPTH];
    logic [KW-1:0]  src_keep [ND][DEPTH];
    int             drv_idx  [ND];
    int             next_idx [ND];
    logic           hs_mux = 1'b0;
    logic [ND-1:0]  hs_src = '0;
    int             rst_req = 0;
    int             valid_pct = 100;
    int             tready_mode = 0;
    logic [ND-1:0]  src_block = '0;
    int             n_checks = 0;
    int             n_pass = 0;

    dest_data_mux #(
        .DATA_BITS (DW),
        .N_DESTS   (ND)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .mux_data      (mux_data),
        .mux_valid     (mux_valid),
        .mux_ready     (mux_ready),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast)
`ifdef DEST_DATA_MUX_STATS_EN
        ,
        .cnt_xfers     (cnt_xfers)
`endif
    );

    always #5 aclk = ~aclk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endfunction

    // Stimulus driver: consumes handshakes seen at the last negedge, then drives
    initial begin
        ent_t  ent;
        beat_t bt;
        int    idx;
        areset        = 1'b1;
        mux_valid     = 1'b0;
        mux_data      = '0;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            if (hs_mux && mux_q.size() > 0) begin
                ent = mux_q.pop_front();
                for (int b = 0; b <= ent.len; b++) begin
                    bt.data = src_data[ent.dest][next_idx[ent.dest]];
                    bt.keep = src_keep[ent.dest][next_idx[ent.dest]];
                    bt.last = (b == ent.len);
                    bt.dest = ent.dest;
                    next_idx[ent.dest]++;
                    exp_q.push_back(bt);
                end
            end
            for (int s = 0; s < ND; s++) begin
                if (hs_src[s]) begin
                    drv_idx[s]++;
                    s_axis_tvalid[s] = 1'b0;
                end
            end
            if (rst_req > 0) begin
                areset = 1'b1;
                rst_req--;
                exp_q.delete();
                for (int s = 0; s < ND; s++) next_idx[s] = drv_idx[s];
            end else begin
                areset = 1'b0;
            end
            for (int s = 0; s < ND; s++) begin
                idx = (drv_idx[s] < DEPTH) ? drv_idx[s] : DEPTH - 1;
                if (src_block[s] || drv_idx[s] >= DEPTH) begin
                    s_axis_tvalid[s] = 1'b0;
                end else if (!s_axis_tvalid[s]) begin
                    s_axis_tvalid[s] = ($urandom_range(0, 99) < valid_pct);
                end
                s_axis_tdata[s] = src_data[s][idx];
                s_axis_tkeep[s] = src_keep[s][idx];
                s_axis_tlast[s] = 1'($urandom_range(0, 1));
            end
            case (tready_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = ($urandom_range(0, 3) != 0);
            endcase
            mux_valid = !areset && (mux_q.size() > 0);
            mux_data  = '0;
            if (mux_q.size() > 0) begin
                mux_data.pid  = PID_BITS'($urandom);
                mux_data.len  = BLEN_BITS'(mux_q[0].len);
                mux_data.dest = N_DESTS_BITS'(mux_q[0].dest);
            end
        end
    end

    // Monitor: derive expected outputs from the beat queue and compare
    initial begin
        beat_t         h;
        logic          exp_tv;
        logic          exp_mr;
        logic [ND-1:0] exp_tr;
        logic          m_hs;
        forever begin
            @(negedge aclk);
            hs_mux = mux_valid && mux_ready;
            hs_src = s_axis_tvalid & s_axis_tready;
            m_hs   = m_axis_tvalid && m_axis_tready;
`ifdef DEST_DATA_MUX_STATS_EN
            if (seen_rst) check("cnt_xfers", 64'(cnt_xfers), 64'(xfers_model));
            if (areset) begin
                seen_rst    = 1'b1;
                xfers_model = 0;
            end else if (m_hs && exp_q.size() > 0 && exp_q[0].last) begin
                xfers_model++;
            end
`endif
            if (areset) begin
                exp_tv = 1'b0;
                exp_tr = '0;
                exp_mr = 1'b0;
            end else if (exp_q.size() > 0) begin
                h      = exp_q[0];
                exp_tv = s_axis_tvalid[h.dest];
                exp_tr = m_axis_tready ? (ND'(1) << h.dest) : '0;
                exp_mr = exp_tv && m_axis_tready && h.last;
            end else begin
                exp_tv = 1'b0;
                exp_tr = '0;
                exp_mr = 1'b1;
            end
            check("m_tvalid", 64'(m_axis_tvalid), 64'(exp_tv));
            check("s_tready", 64'(s_axis_tready), 64'(exp_tr));
            check("mux_ready", 64'(mux_ready), 64'(exp_mr));
            if (!areset && exp_q.size() > 0 && m_axis_tvalid) begin
                h = exp_q[0];
                check("m_tdata", 64'(m_axis_tdata), 64'(h.data));
                check("m_tkeep", 64'(m_axis_tkeep), 64'(h.keep));
                check("m_tlast", 64'(m_axis_tlast), 64'(h.last));
                if (m_axis_tready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic push_ent(input int dest, input int len);
        ent_t e;
        e.dest = dest;
        e.len  = len;
        mux_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && mux_q.size() == 0 && rst_req == 0) break;
            @(posedge aclk);
        end
        check("drain", 64'(exp_q.size() + mux_q.size()), 64'd0);
        repeat (2) @(posedge aclk);
    endtask

    task automatic wait_left(input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (mux_q.size() == 0 && exp_q.size() > 0 && exp_q.size() <= n) break;
            @(posedge aclk);
            #2;
        end
        check("progress", 64'(i < budget), 64'd1);
    endtask

    // Scenario sequence
    initial begin
        for (int s = 0; s < ND; s++) begin
            drv_idx[s]  = 0;
            next_idx[s] = 0;
            for (int k = 0; k < DEPTH; k++) begin
                src_data[s][k] = $urandom;
                src_keep[s][k] = KW'($urandom);
            end
        end
        for (int k = 0; k < 4; k++) src_data[2][k] = 32'hA0 + 32'(k);
        rst_req = 3;
        repeat (5) @(posedge aclk);

        // Single transfer from source 2
        push_ent(2, 3);
        wait_idle(100);

        // Back-to-back entries, one with len = 0
        push_ent(0, 1);
        push_ent(1, 0);
        wait_idle(100);

        // Output backpressure toggling every cycle
        tready_mode = 1;
        push_ent(1, 7);
        wait_idle(200);
        tready_mode = 0;

        // Source starvation mid-transfer
        push_ent(3, 7);
        wait_left(5, 100);
        src_block[3] = 1'b1;
        repeat (5) @(posedge aclk);
        src_block[3] = 1'b0;
        wait_idle(100);

        // Reset during a transfer, then a fresh entry
        push_ent(0, 5);
        wait_left(4, 100);
        rst_req = 2;
        repeat (4) @(posedge aclk);
        push_ent(2, 2);
        wait_idle(100);

        // Randomised traffic with random source and output stalls
        valid_pct   = 60;
        tready_mode = 2;
        for (int t = 0; t < 40; t++) begin
            push_ent(int'($urandom_range(0, ND - 1)), int'($urandom_range(0, 7)));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 6)) @(posedge aclk);
            if (t == 20) begin
                wait_left(3, 500);
                rst_req = 1;
            end
        end
        wait_idle(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dest_data_mux.md
DEST_DATA_MUX -- requirements
Module: dest_data_mux

Interface
REQ-001 SHALL have parameter DATA_BITS, default AXI_DATA_BITS, stream data width.
REQ-002 SHALL have parameter N_DESTS, default 1, number of source streams.
REQ-003 SHALL use one clock and a synchronous, active-high reset: aclk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have areset  input  1  synchronous active-high reset.
REQ-005 SHALL have mux  metaIntf.s (mux_user_t)  -  routing sequence {pid, len = beats-1 (BLEN_BITS), dest (N_DESTS_BITS)}.
REQ-006 SHALL have s_axis  AXI4S.s [N_DESTS]  DATA_BITS  per-source data streams.
REQ-007 SHALL have m_axis  AXI4S.m  DATA_BITS  merged output stream.

Function
REQ-008 SHALL implement an FSM with states IDLE and XFER.
REQ-009 In IDLE: mux.ready = 1, m_axis.tvalid = 0, all s_axis[i].tready = 0.
REQ-010 On mux handshake in IDLE: latch dest and len, clear beat counter to 0, enter XFER next cycle.
REQ-011 In XFER: m_axis.tvalid = s_axis[dest].tvalid; m_axis.tdata/tkeep = s_axis[dest] fields; s_axis[dest].tready = m_axis.tready; all other s_axis tready = 0.
REQ-012 In XFER: m_axis.tlast = (counter == len); source tlast ignored.
REQ-013 On each m_axis handshake in XFER: counter increments by 1 (BLEN_BITS wide, no wrap, since it stops at len).
REQ-014 On last-beat handshake: mux.ready = 1 in that same cycle; if mux.valid, latch the new entry and stay in XFER with counter = 0 (zero-bubble back-to-back); else return to IDLE.
REQ-015 In XFER, except during the last-beat handshake: mux.ready = 0.
REQ-016 len = 0 SHALL produce exactly one beat with tlast = 1.
REQ-017 Combinational path latency data-in to data-out SHALL be 0 cycles; no data buffering.
REQ-018 Throughput SHALL be 1 beat/cycle with no idle cycle between consecutive transfers when mux is valid.
REQ-019 Data beats on non-selected sources SHALL stall, never be dropped or reordered.
REQ-020 With N_DESTS = 1, dest SHALL be ignored and source 0 always selected.
REQ-021 m_axis.tvalid SHALL NOT depend on m_axis.tready (AXI-Stream rule).

Reset
REQ-022 While areset = 1: state = IDLE, counter = 0, dest/len registers = 0, mux.ready = 0, m_axis.tvalid = 0, all s_axis tready = 0.
REQ-023 Reset asserted mid-XFER SHALL abandon the transfer; no partial beat emitted after release; first cycle after release is IDLE.

Configuration
REQ-024 Macro DEST_DATA_MUX_STATS_EN SHALL, when defined, add output port cnt_xfers (32 bits): completed transfers (last-beat handshakes), reset to 0, wraps at 2^32.
REQ-025 Without DEST_DATA_MUX_STATS_EN, port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-026 mux_user_t, BLEN_BITS, AXI_DATA_BITS and clog2s SHALL come from the shared package lynxTypes; no new package types.
REQ-027 FSM enum (IDLE, XFER) SHALL be local to the module.
REQ-028 No sub-module SHALL be instantiated; FSM, counter and selection mux are inline.

Verification
REQ-029 Single transfer: mux {dest=2, len=3}, N_DESTS=4, source 2 streams 0xA0..0xA3 -> m_axis emits 4 beats, tlast only on 0xA3, sources 0,1,3 tready held 0.
REQ-030 Back-to-back: mux entries {dest=0,len=1},{dest=1,len=0} queued -> 3 consecutive beats, no idle cycle, tlast on beats 2 and 3.
REQ-031 Backpressure: m_axis.tready toggled 1/0 each cycle during {dest=1,len=7} -> 8 beats in order, tdata stable while tvalid && !tready.
REQ-032 Source starvation: s_axis[dest].tvalid low for 5 cycles mid-transfer -> m_axis.tvalid low for those 5 cycles, counter unchanged.
REQ-033 Reset mid-transfer: areset pulsed after beat 2 of len=5 -> all outputs at reset values next cycle, IDLE after release, next mux entry transfers correctly.
REQ-034 With DEST_DATA_MUX_STATS_EN: 3 transfers complete -> cnt_xfers = 3; after reset -> 0.
